// File: rtl/sniffer_pkg.sv
// Shared types, default dimensions and width helpers for the sniffer datapath.
package sniffer_pkg;

    typedef logic [7:0] byte_t;

    localparam int DEF_LANES        = 4;
    localparam int DEF_MAX_LEN      = 16;
    localparam int DEF_NUM_PATTERNS = 4;

    // Index width for n items, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the values 0..n inclusive.
    function automatic int len_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pattern_match_slot.sv
// One programmable pattern slot: stores a right-aligned pattern plus byte mask and
// checks it against the history window ending at every lane of the current word.
module pattern_match_slot
    import sniffer_pkg::*;
#(
    parameter int  LANES   = DEF_LANES,
    parameter int  MAX_LEN = DEF_MAX_LEN,
    localparam int HIST    = MAX_LEN + LANES - 1,
    localparam int WIN     = HIST + LANES,
    localparam int LEN_W   = len_w(MAX_LEN),
    localparam int FILL_W  = len_w(HIST)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 cfg_we,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic [8*MAX_LEN-1:0] cfg_string,
    input  logic [8*WIN-1:0]     window,
    input  logic [FILL_W-1:0]    fill,
    output logic                 hit
);

    logic [LEN_W-1:0]     len_q, len_d, len_c;
    logic [8*MAX_LEN-1:0] pat_q, pat_d;
    logic [MAX_LEN-1:0]   mask_q, mask_d;
    logic                 lane_ok;
    byte_t                win_b, pat_b;

    // The pattern is stored with its last byte in the top slot so the compare
    // below only uses constant byte positions.
    always_comb begin
        len_c  = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
        len_d  = len_q;
        pat_d  = pat_q;
        mask_d = mask_q;
        if (cfg_we) begin
            len_d = len_c;
            pat_d = cfg_string << (8 * (MAX_LEN - int'(len_c)));
            for (int i = 0; i < MAX_LEN; i++) begin
                mask_d[i] = (i >= MAX_LEN - int'(len_c));
            end
        end
    end

    always_comb begin
        hit     = 1'b0;
        lane_ok = 1'b0;
        win_b   = '0;
        pat_b   = '0;
        for (int e = 0; e < LANES; e++) begin
            lane_ok = (len_q != '0) && (int'(fill) + e + 1 >= int'(len_q));
            for (int k = 0; k < MAX_LEN; k++) begin
                win_b = window[8*(HIST+e-k) +: 8];
                pat_b = pat_q[8*(MAX_LEN-1-k) +: 8];
                if (mask_q[MAX_LEN-1-k] && (win_b != pat_b)) begin
                    lane_ok = 1'b0;
                end
            end
            hit = hit | lane_ok;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            len_q  <= '0;
            pat_q  <= '0;
            mask_q <= '0;
        end else begin
            len_q  <= len_d;
            pat_q  <= pat_d;
            mask_q <= mask_d;
        end
    end

endmodule

// File: rtl/multi_string_matcher.sv
// Multi-pattern byte-string matcher: byte history, fill tracking, per-slot compare,
// registered results aligned with the delayed data word, and a sticky frame hit vector.
module multi_string_matcher
    import sniffer_pkg::*;
#(
    parameter int  LANES        = DEF_LANES,
    parameter int  MAX_LEN      = DEF_MAX_LEN,
    parameter int  NUM_PATTERNS = DEF_NUM_PATTERNS,
    localparam int HIST         = MAX_LEN + LANES - 1,
    localparam int WIN          = HIST + LANES,
    localparam int LEN_W        = len_w(MAX_LEN),
    localparam int FILL_W       = len_w(HIST),
    localparam int ID_W         = idx_w(NUM_PATTERNS)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    data_valid,
    input  logic [8*LANES-1:0]      data_in,
    input  logic                    cfg_we,
    input  logic [ID_W-1:0]         cfg_idx,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic [8*MAX_LEN-1:0]    cfg_string,
    output logic [8*LANES-1:0]      data_out,
    output logic                    data_out_valid,
    output logic                    match,
    output logic [NUM_PATTERNS-1:0] match_vec,
    output logic [ID_W-1:0]         match_id,
    output logic [NUM_PATTERNS-1:0] frame_hit
);

    logic [8*HIST-1:0]       hist_q, hist_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic [8*LANES-1:0]      data_out_q, data_out_d;
    logic                    data_out_valid_q, data_out_valid_d;
    logic                    match_q, match_d;
    logic [NUM_PATTERNS-1:0] match_vec_q, match_vec_d;
    logic [ID_W-1:0]         match_id_q, match_id_d;
    logic [NUM_PATTERNS-1:0] frame_hit_q, frame_hit_d;
    logic [NUM_PATTERNS-1:0] hits;
    logic [8*WIN-1:0]        window;

    // Byte order in the window follows wire order: oldest history byte at the bottom,
    // the incoming word's lanes on top.
    assign window = {data_in, hist_q};

    for (genvar p = 0; p < NUM_PATTERNS; p++) begin : g_slot
        pattern_match_slot #(
            .LANES  (LANES),
            .MAX_LEN(MAX_LEN)
        ) u_slot (
            .clk       (clk),
            .n_rst     (n_rst),
            .cfg_we    (cfg_we && (cfg_idx == ID_W'(p))),
            .cfg_len   (cfg_len),
            .cfg_string(cfg_string),
            .window    (window),
            .fill      (fill_q),
            .hit       (hits[p])
        );
    end

    always_comb begin
        hist_d           = hist_q;
        fill_d           = fill_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        match_d          = 1'b0;
        match_vec_d      = '0;
        match_id_d       = '0;
        frame_hit_d      = frame_hit_q;
        if (clear) begin
            fill_d      = '0;
            frame_hit_d = '0;
        end else if (data_valid) begin
            hist_d           = window[8*WIN-1 -: 8*HIST];
            fill_d           = (int'(fill_q) + LANES >= HIST) ? FILL_W'(HIST)
                                                              : fill_q + FILL_W'(LANES);
            data_out_d       = data_in;
            data_out_valid_d = 1'b1;
            match_d          = |hits;
            match_vec_d      = hits;
            for (int p = NUM_PATTERNS - 1; p >= 0; p--) begin
                if (hits[p]) begin
                    match_id_d = ID_W'(p);
                end
            end
            frame_hit_d = frame_hit_q | hits;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hist_q           <= '0;
            fill_q           <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            match_q          <= 1'b0;
            match_vec_q      <= '0;
            match_id_q       <= '0;
            frame_hit_q      <= '0;
        end else begin
            hist_q           <= hist_d;
            fill_q           <= fill_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            match_q          <= match_d;
            match_vec_q      <= match_vec_d;
            match_id_q       <= match_id_d;
            frame_hit_q      <= frame_hit_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign match          = match_q;
    assign match_vec      = match_vec_q;
    assign match_id       = match_id_q;
    assign frame_hit      = frame_hit_q;

endmodule

// File: doc/multi_string_matcher.md
# multi_string_matcher

Parametrised multi-pattern byte-string matcher for the Ethernet sniffer datapath. Accepts a stream of LANES-byte words and checks every byte alignment against NUM_PATTERNS runtime-programmable corrupt strings of up to MAX_LEN bytes, including matches that span word boundaries. Reports per-pattern hits, the lowest hitting index and a per-frame sticky hit vector, and passes the data through one cycle later, aligned with the match result. Sits between the packet-word framer and the flagging/forwarding logic; patterns are programmed by the Atom through the config port.

## Interface
- LANES, 4, bytes per data word (≥1)
- MAX_LEN, 16, maximum pattern length in bytes (≥1)
- NUM_PATTERNS, 4, number of pattern slots (≥1)
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous frame clear
- data_valid  in  1  data_in holds a valid word this cycle
- data_in  in  8*LANES  stream word; lane k = data_in[8k+7:8k]; lane 0 first on wire
- cfg_we  in  1  write one pattern slot
- cfg_idx  in  $clog2(NUM_PATTERNS) (min 1)  slot to write
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length; 0 disables the slot
- cfg_string  in  8*MAX_LEN  pattern bytes; byte 0 = cfg_string[7:0] = first char
- data_out  out  8*LANES  data_in delayed by one accepted cycle
- data_out_valid  out  1  data_out is valid
- match  out  1  any slot hit in the word on data_out
- match_vec  out  NUM_PATTERNS  per-slot hit for the word on data_out
- match_id  out  $clog2(NUM_PATTERNS) (min 1)  lowest set index of match_vec; 0 if none
- frame_hit  out  NUM_PATTERNS  sticky OR of match_vec since the last clear/reset

## Operation
- History: shift register of MAX_LEN+LANES-1 bytes plus a saturating fill counter (saturates at MAX_LEN+LANES-1). On an accepted word (data_valid=1, clear=0), LANES bytes shift in and fill += LANES.
- Slot p (length L, 1..MAX_LEN) hits when, for some lane e of the accepted word, the L bytes ending at lane e equal pattern bytes 0..L-1 in wire order, and at least L bytes have been received since the last clear/reset. Bytes never received never match, including zero patterns.
- Evaluation uses the history before the shift plus data_in; results are registered.
- Slots with len 0 never hit. cfg_idx ≥ NUM_PATTERNS: write ignored. cfg_len > MAX_LEN: clamped to MAX_LEN.
- A config write takes effect for words accepted on the following cycle and later; a word accepted in the same cycle as the write uses the old slot contents.
- clear: empties the history (fill=0) and zeroes match, match_vec, match_id, data_out_valid and frame_hit; pattern slots are kept. If clear and data_valid are both high, clear wins and the word is dropped.
- Reset: everything zero, including all slots (disabled) and data_out.

## Timing
- Latency 1: a word accepted at edge N appears on data_out with data_out_valid=1 and its match results after edge N.
- data_valid=0 cycle: no shift; next cycle data_out_valid=0, match=0, match_vec=0; data_out holds its value. Gaps between words do not break cross-word matches.
- frame_hit updates in the same cycle as match_vec.
- Reset mid-pattern: partial history discarded; a match needs the full pattern re-received after reset and re-programming.

## Structure
- sniffer_pkg: byte typedef, default LANES/MAX_LEN/NUM_PATTERNS constants, width helper functions.
- Sub-module pattern_match_slot, one per slot (generate loop): holds len and string registers and the config write; compares the history window at all LANES end offsets and outputs a combinational hit. The top level holds the history, fill counter, priority encoder, output registers and frame_hit.

## Test plan
Defaults LANES=4, MAX_LEN=16, NUM_PATTERNS=4.
- Slot 0 = "EVIL" (len 4); send word with lanes 0..3 = 'E','V','I','L' -> next cycle match=1, match_vec=4'b0001, match_id=0, data_out equals the sent word.
- Slot 2 = "BADWORD"; send 'x','x','B','A' then 'D','W','O','R' then 'D',.. with a data_valid gap after the second word -> match only on the third word, match_vec=4'b0100, match_id=2.
- Slot 1 = four 0x00 bytes; after clear send idle cycles, then one all-zero word -> no match while idle; match_vec=4'b0010 on the zero word.
- Slots 1 and 2 both matching in the same word -> match_vec=4'b0110, match_id=1; frame_hit stays 4'b0110 until clear, then 0.
- "EVIL" split across two words with clear between them -> no match. Write slot 0 with len 0 in the same cycle as a hitting word -> that word still hits; the next identical word does not.
- Assert n_rst mid-stream -> all outputs 0 immediately; after release, a previously programmed pattern no longer matches.
